// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction-fetch front-end: buffer entry layout and fetch FSM states.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_REQ,
    FS_DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response and fetch-buffer dequeue handshake for fetch_unit.
interface fetch_unit_if #(
  parameter int unsigned width = 32
) ();

  logic             i_mem_resp;
  logic [width-1:0] i_mem_rdata;
  logic             i_mem_read;
  logic [width-1:0] i_mem_address;

  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] out_instr;
  logic [width-1:0] out_pc;
  logic             out_pred_taken;

  modport master (
    input  i_mem_resp, i_mem_rdata, out_ready,
    output i_mem_read, i_mem_address, out_valid, out_instr, out_pc, out_pred_taken
  );

  modport slave (
    output i_mem_resp, i_mem_rdata, out_ready,
    input  i_mem_read, i_mem_address, out_valid, out_instr, out_pc, out_pred_taken
  );

endinterface

// File: rtl/fetch_buffer.sv
// Circular FIFO of fetched entries with registered head, synchronous clear and occupancy count.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int unsigned depth = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int unsigned PtrW = (depth > 1) ? $clog2(depth) : 1,
  localparam int unsigned CntW = $clog2(depth + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enq,
  input  entry_t          enq_data,
  input  logic            deq,
  input  logic            clear,
  output entry_t          head,
  output logic [CntW-1:0] count,
  output logic            full,
  output logic            empty
);

  entry_t          mem_q [depth];
  logic [PtrW-1:0] rptr_q, wptr_q;
  logic [CntW-1:0] count_q;
  logic            do_enq, do_deq;

  assign full   = (count_q == CntW'(depth));
  assign empty  = (count_q == '0);
  assign do_enq = enq & ~full & ~clear;
  assign do_deq = deq & ~empty & ~clear;
  assign count  = count_q;
  assign head   = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_enq) mem_q[wptr_q] <= enq_data;
  end

  // depth is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_enq) wptr_q <= wptr_q + PtrW'(1);
      if (do_deq) rptr_q <= rptr_q + PtrW'(1);
      if (do_enq && !do_deq)      count_q <= count_q + CntW'(1);
      else if (!do_enq && do_deq) count_q <= count_q - CntW'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front-end: PC owner, single-outstanding I-mem reads, prioritised redirects, fetch buffer.
// Optional perf counters enabled by defining FETCH_PERF_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned      width      = 32,
  parameter int unsigned      fb_depth   = 4,
  parameter int unsigned      n_redirect = 2,
  parameter logic [width-1:0] reset_pc   = width'(32'h00000060)
) (
  input  logic                        clk,
  input  logic                        rst,
  fetch_unit_if.master                bus,
  input  logic                        pred_taken,
  input  logic [width-1:0]            pred_target,
  output logic [width-1:0]            pc_out,
  input  logic [n_redirect-1:0]       redirect_valid,
  input  logic [n_redirect*width-1:0] redirect_pc,
  output logic                        full
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                 perf_fetched,
  output logic [31:0]                 perf_discarded,
  output logic [31:0]                 perf_stall
`endif
);

  localparam int unsigned CntW = $clog2(fb_depth + 1);

  typedef struct packed {
    logic [width-1:0] instr;
    logic [width-1:0] pc;
    logic             pred_taken;
  } entry_t;

  fetch_state_t     state_q, state_d;
  logic [width-1:0] pc_q, pc_d, addr_q, addr_d, redir_pc;
  logic             redir_any, enq, deq, drop;
  logic             buf_full, buf_empty;
  logic [CntW-1:0]  count;
  entry_t           enq_entry, head;

  assign redir_any = |redirect_valid;

  // Walk from the highest index down so the lowest set channel wins.
  always_comb begin
    redir_pc = '0;
    for (int k = n_redirect - 1; k >= 0; k--) begin
      if (redirect_valid[k]) redir_pc = redirect_pc[k*width +: width];
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    enq     = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      FS_IDLE: begin
        if (!redir_any && (32'(count) + 32'd1 <= fb_depth)) begin
          state_d = FS_REQ;
          addr_d  = pc_q;
        end
      end
      FS_REQ: begin
        if (redir_any) begin
          state_d = bus.i_mem_resp ? FS_IDLE : FS_DRAIN;
          drop    = bus.i_mem_resp;
        end else if (bus.i_mem_resp) begin
          enq     = 1'b1;
          pc_d    = pred_taken ? pred_target : pc_q + width'(4);
          state_d = FS_IDLE;
        end
      end
      FS_DRAIN: begin
        if (bus.i_mem_resp) begin
          state_d = FS_IDLE;
          drop    = 1'b1;
        end
      end
      default: state_d = FS_IDLE;
    endcase
    if (redir_any) pc_d = redir_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FS_IDLE;
      pc_q    <= reset_pc;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  assign enq_entry = '{instr: bus.i_mem_rdata, pc: pc_q, pred_taken: pred_taken};
  assign deq       = ~buf_empty & bus.out_ready & ~redir_any;

  fetch_buffer #(
    .depth  (fb_depth),
    .entry_t(entry_t)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .enq     (enq),
    .enq_data(enq_entry),
    .deq     (deq),
    .clear   (redir_any),
    .head    (head),
    .count   (count),
    .full    (buf_full),
    .empty   (buf_empty)
  );

  assign bus.i_mem_read     = (state_q != FS_IDLE);
  assign bus.i_mem_address  = addr_q;
  assign bus.out_valid      = ~buf_empty;
  assign bus.out_instr      = head.instr;
  assign bus.out_pc         = head.pc;
  assign bus.out_pred_taken = head.pred_taken;
  assign pc_out             = pc_q;
  assign full               = buf_full;

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, discarded_q, stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q   <= '0;
      discarded_q <= '0;
      stall_q     <= '0;
    end else begin
      if (enq && fetched_q != '1)  fetched_q   <= fetched_q + 32'd1;
      if (drop && discarded_q != '1) discarded_q <= discarded_q + 32'd1;
      if (state_q == FS_IDLE && buf_full && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_fetched   = fetched_q;
  assign perf_discarded = discarded_q;
  assign perf_stall     = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model plus directed scenarios.
module tb_fetch_unit;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 4;
  localparam int unsigned NR = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pred_taken;
  logic [W-1:0]  pred_target, pc_out;
  logic [NR-1:0] redirect_valid;
  logic [NR*W-1:0] redirect_pc;
  logic          full;
`ifdef FETCH_PERF_EN
  logic [31:0]   perf_fetched, perf_discarded, perf_stall;
`endif

  always #5 clk = ~clk;

  fetch_unit_if #(.width(W)) bus ();

  fetch_unit #(
    .width     (W),
    .fb_depth  (D),
    .n_redirect(NR),
    .reset_pc  (32'h00000060)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .pc_out        (pc_out),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .full          (full)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_discarded(perf_discarded),
    .perf_stall    (perf_stall)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a * 32'd3 + 32'h1000_0000;
  endfunction

  // Reference model: abstract fetcher state plus a queue of buffered entries.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc, m_addr;
  bit          m_busy, m_drop;
  int          m_occ, m_fetched, m_discarded, m_stall;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 32'h60; m_addr = '0; m_busy = 0; m_drop = 0; m_q.delete();
      m_fetched = 0; m_discarded = 0; m_stall = 0;
    end else begin
      m_occ = m_q.size();
      if (!m_busy && m_occ == D) m_stall++;
      if (redirect_valid != '0) begin
        m_pc = redirect_valid[0] ? redirect_pc[31:0] : redirect_pc[63:32];
        m_q.delete();
        if (m_busy && bus.i_mem_resp) begin
          m_busy = 0; m_drop = 0; m_discarded++;
        end else if (m_busy) begin
          m_drop = 1;
        end
      end else begin
        if (m_occ > 0 && bus.out_ready) void'(m_q.pop_front());
        if (m_busy && bus.i_mem_resp) begin
          if (m_drop) m_discarded++;
          else begin
            m_q.push_back('{instr: bus.i_mem_rdata, pc: m_pc, pred: pred_taken});
            m_fetched++;
            m_pc = pred_taken ? pred_target : m_pc + 32'd4;
          end
          m_busy = 0; m_drop = 0;
        end else if (!m_busy && m_occ < D) begin
          m_busy = 1; m_addr = m_pc;
        end
      end
    end
  end

  // Observation logs used by the directed scenarios.
  logic [31:0] issued[$];
  ent_t        deq_log[$];
  bit          read_prev = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_read", bus.i_mem_read, m_busy);
      if (m_busy) chk("mem_address", bus.i_mem_address, m_addr);
      chk("pc_out", pc_out, m_pc);
      chk("out_valid", bus.out_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("out_instr", bus.out_instr, m_q[0].instr);
        chk("out_pc", bus.out_pc, m_q[0].pc);
        chk("out_pred_taken", bus.out_pred_taken, m_q[0].pred);
      end
      chk("full", full, m_q.size() == D);
`ifdef FETCH_PERF_EN
      chk("perf_fetched", perf_fetched, m_fetched);
      chk("perf_discarded", perf_discarded, m_discarded);
      chk("perf_stall", perf_stall, m_stall);
`endif
    end
    if (bus.i_mem_read && !read_prev) issued.push_back(bus.i_mem_address);
    read_prev = bus.i_mem_read;
    if (bus.out_valid && bus.out_ready && redirect_valid == '0)
      deq_log.push_back('{instr: bus.out_instr, pc: bus.out_pc, pred: bus.out_pred_taken});
  end

  // Stimulus knobs: auto memory responder and a one-PC predictor.
  bit          auto_en = 0;
  int          lat = 0, wait_cnt = 0;
  bit          pred_en = 0;
  logic [31:0] pred_at = '0, pred_tgt = '0;

  task automatic cyc();
    @(negedge clk);
    #1;
    redirect_valid  = '0;
    pred_taken      = pred_en && (pc_out == pred_at);
    pred_target     = pred_tgt;
    bus.i_mem_resp  = 1'b0;
    if (auto_en && bus.i_mem_read) begin
      if (wait_cnt >= lat) begin
        bus.i_mem_resp  = 1'b1;
        bus.i_mem_rdata = word_of(bus.i_mem_address);
        wait_cnt = 0;
      end else wait_cnt++;
    end else wait_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    issued.delete();
    deq_log.delete();
    rst = 1'b0;
  endtask

  task automatic run_until_issued(input int n, input int budget);
    for (int i = 0; i < budget && issued.size() < n; i++) cyc();
    chk("issue_wait", issued.size() >= n, 1'b1);
  endtask

  initial begin
    bus.i_mem_resp  = 1'b0;
    bus.i_mem_rdata = '0;
    bus.out_ready   = 1'b0;
    pred_taken      = 1'b0;
    pred_target     = '0;
    redirect_valid  = '0;
    redirect_pc     = '0;

    // Reset state and sequential fetch.
    do_reset();
    chk_en = 1'b1;
    chk("rst_read", bus.i_mem_read, 1'b0);
    chk("rst_pc", pc_out, 32'h60);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_full", full, 1'b0);
    bus.out_ready = 1'b1; auto_en = 1; lat = 0;
    repeat (12) cyc();
    chk("t1_addr0", issued[0], 32'h60);
    chk("t1_addr1", issued[1], 32'h64);
    chk("t1_addr2", issued[2], 32'h68);
    chk("t1_deq0_pc", deq_log[0].pc, 32'h60);
    chk("t1_deq0_instr", deq_log[0].instr, 32'h1000_0120);
    chk("t1_deq1_pc", deq_log[1].pc, 32'h64);
    chk("t1_deq2_pc", deq_log[2].pc, 32'h68);

    // Back-pressure: fill to depth, then release exactly one entry.
    do_reset();
    bus.out_ready = 1'b0; auto_en = 1; lat = 0;
    repeat (20) cyc();
    chk("t2_req_count", issued.size(), 4);
    chk("t2_full", full, 1'b1);
    chk("t2_read_idle", bus.i_mem_read, 1'b0);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    repeat (6) cyc();
    chk("t2_req_after_deq", issued.size(), 5);
    chk("t2_refull", full, 1'b1);
    chk("t2_deq_count", deq_log.size(), 1);

    // Predicted-taken at 0x64 steers the next fetch to 0x200.
    do_reset();
    pred_en = 1; pred_at = 32'h64; pred_tgt = 32'h200;
    bus.out_ready = 1'b1; auto_en = 1; lat = 0;
    repeat (10) cyc();
    pred_en = 0;
    chk("t3_addr2", issued[2], 32'h200);
    chk("t3_addr3", issued[3], 32'h204);
    chk("t3_deq0_pred", deq_log[0].pred, 1'b0);
    chk("t3_deq1_pc", deq_log[1].pc, 32'h64);
    chk("t3_deq1_pred", deq_log[1].pred, 1'b1);
    chk("t3_deq2_pc", deq_log[2].pc, 32'h200);

    // Redirect ch1 during REQ, response arrives three cycles later and is dropped.
    do_reset();
    bus.out_ready = 1'b0; auto_en = 1; lat = 2;
    run_until_issued(2, 20);
    auto_en = 0;
    chk("t4_valid_before", bus.out_valid, 1'b1);
    redirect_valid = 2'b10;
    redirect_pc    = {32'h400, 32'h0};
    cyc(); cyc(); cyc();
    bus.i_mem_resp  = 1'b1;
    bus.i_mem_rdata = word_of(32'h64);
    cyc();
    chk("t4_read_done", bus.i_mem_read, 1'b0);
    chk("t4_empty", bus.out_valid, 1'b0);
    chk("t4_pc", pc_out, 32'h400);
    cyc(); cyc();
    chk("t4_req_count", issued.size(), 3);
    chk("t4_next_addr", issued[2], 32'h400);

    // Two redirects plus a response in the same cycle: ch0 wins, response discarded.
    do_reset();
    bus.out_ready = 1'b1; auto_en = 0;
    run_until_issued(1, 10);
    redirect_valid  = 2'b11;
    redirect_pc     = {32'h300, 32'h100};
    bus.i_mem_resp  = 1'b1;
    bus.i_mem_rdata = word_of(32'h60);
    cyc();
    chk("t5_idle", bus.i_mem_read, 1'b0);
    chk("t5_pc", pc_out, 32'h100);
    chk("t5_empty", bus.out_valid, 1'b0);
    cyc();
    chk("t5_req_count", issued.size(), 2);
    chk("t5_next_addr", issued[1], 32'h100);

    // Reset while a request is outstanding; a stray response afterwards is ignored.
    do_reset();
    bus.out_ready = 1'b1; auto_en = 1; lat = 2;
    run_until_issued(3, 30);
    auto_en = 0;
    chk("t6_addr2", issued[2], 32'h68);
    rst = 1'b1;
    cyc();
    chk("t6_rst_read", bus.i_mem_read, 1'b0);
    chk("t6_rst_pc", pc_out, 32'h60);
    chk("t6_rst_valid", bus.out_valid, 1'b0);
    issued.delete();
    deq_log.delete();
    rst = 1'b0;
    bus.i_mem_resp  = 1'b1;
    bus.i_mem_rdata = 32'hBAD0_BAD0;
    cyc();
    chk("t6_stray_valid", bus.out_valid, 1'b0);
    chk("t6_restart_count", issued.size(), 1);
    chk("t6_restart_addr", issued[0], 32'h60);
    auto_en = 1;
    repeat (8) cyc();
    chk("t6_deq0_pc", deq_log[0].pc, 32'h60);
    chk("t6_deq0_instr", deq_log[0].instr, 32'h1000_0120);

    auto_en = 0;
    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
